nexus_work_scheduler: RTL and testbench
=======================================

NEXUS_WORK_SCHEDULER -- requirements
Module: nexus_work_scheduler

Interface
REQ-001 Parameter: HASHERS, default 4, number of attached hash cores.
REQ-002 Parameter: PIPE_LAT, default 391, cycles from core reset release to the first core result (core pipeline depth plus its output register).
REQ-003 Parameter: FIFO_DEPTH, default 8, result FIFO entries; must be a power of two.
REQ-004 Port: clk  in  1  sole clock; all logic is rising-edge.
REQ-005 Port: nHashRst  in  1  asynchronous, active-low reset.
REQ-006 Port: WorkPkt  in  1728  work packet: midstate [1087:0], header tail [1727:1088].
REQ-007 Port: StartNonce  in  64  first nonce of the job.
REQ-008 Port: NonceCount  in  64  nonces to sweep; 0 means unbounded.
REQ-009 Port: WorkValid / WorkReady  in / out  1 / 1  job handshake; transfers on a cycle where both are high.
REQ-010 Port: CoreWorkPkt  out  1728  registered copy of the accepted WorkPkt, fanned out to all cores.
REQ-011 Port: CoreInNonce  out  64  registered StartNonce; core i adds its own index i.
REQ-012 Port: CoreRstN  out  1  shared synchronous active-low core reload strobe.
REQ-013 Port: CoreGood  in  HASHERS  per-core good-nonce flags.
REQ-014 Port: CoreNonce  in  64*HASHERS  per-core nonces; core i occupies [64*i+:64].
REQ-015 Port: ResultNonce / ResultValid / ResultReady  out / out / in  64 / 1 / 1  result stream; pops when ResultValid and ResultReady are both high.
REQ-016 Port: Busy  out  1  high in the LOAD, RUN and FLUSH states.
REQ-017 Port: Done  out  1  one-cycle pulse when a bounded job completes.

Function
REQ-018 FSM states: IDLE, LOAD, RUN, FLUSH.
- WorkReady = 1 in IDLE and RUN; 0 in LOAD and FLUSH.
REQ-019 Transitions:
- IDLE: on handshake, capture WorkPkt, StartNonce and NonceCount, then go to LOAD.
- LOAD: lasts exactly 1 cycle with CoreRstN = 0; CoreRstN = 1 in every other state.
REQ-020 RUN: the 64-bit issued counter starts at 0 and adds HASHERS per cycle.
- Go to FLUSH on the cycle where issued + HASHERS >= NonceCount, compared unsigned with a 65-bit intermediate.
- If NonceCount = 0, never leave RUN on this count.
REQ-021 RUN: a new job handshake preempts the current job; capture the new job and go to LOAD; in-flight results are discarded per REQ-023.
REQ-022 FLUSH: hold for PIPE_LAT cycles while still collecting results, then go to IDLE and pulse Done for 1 cycle.
REQ-023 Result masking: ignore CoreGood during LOAD and the cycle after LOAD; clear all pending registers on entry to LOAD.
REQ-024 Capture: each core has a 1-deep pending register (nonce plus valid bit).
- A set CoreGood loads the register when it is empty, or when it is being granted in the same cycle.
- Otherwise the new hit is dropped.
REQ-025 Arbitration:
- Round-robin over pending registers; at most one grant per cycle, and only when the FIFO is not full.
- The pointer advances to one past the granted core.
REQ-026 FIFO:
- ResultValid = not empty; ResultNonce = head entry.
- Push and pop in the same cycle are allowed when full.
- Push and pop in the same cycle are allowed when empty (empty stays empty only if nothing is pushed).
REQ-027 Nonce arithmetic is modulo 2^64; CoreInNonce + i wraps without error.
REQ-028 Latency: a CoreGood seen at edge t, with an empty pending register, a free FIFO and no contention, reaches ResultValid at edge t+2.

Reset
REQ-029 Asynchronous assert, synchronous deassert (externally synchronised) puts the block in this state:
- State IDLE, WorkReady = 1, CoreRstN = 0, Busy = 0, Done = 0.
- FIFO empty, ResultValid = 0, ResultNonce = 0.
- All pending registers and counters zero; CoreWorkPkt = 0 and CoreInNonce = 0.
REQ-030 Reset mid-job abandons the job; no Done pulse is produced.

Configuration
REQ-031 Macro NXS_DROP_CNT_EN:
- Defined: add output DropCnt (16 bits), a saturating count of hits dropped under REQ-024; reset to 0 and cleared on entry to LOAD.
- Undefined: the DropCnt port and its logic are absent.

Structure
REQ-032 Package nexus_sched_pkg holds:
- The state enum.
- Constants NONCE_W = 64 and WORK_W = 1728.
- The default PIPE_LAT.
REQ-033 Sub-module nexus_result_fifo (parameterised depth and width) implements the result FIFO; the arbiter and FSM stay in the top level.

Verification
REQ-034 Job StartNonce = 0x100, NonceCount = 8, HASHERS = 4:
- LOAD for 1 cycle, then RUN for 2 cycles, then FLUSH for 391 cycles.
- Done pulses once; CoreInNonce = 0x100.
REQ-035 Cores 0, 1 and 3 assert CoreGood in the same cycle, ResultReady = 1:
- Results appear on 3 consecutive cycles in order 0, 1, 3.
- The next grant starts from core 0.
REQ-036 ResultReady = 0 with 9 single hits:
- The FIFO fills with 8 entries and holds the 9th in pending.
- A further hit on the same core is dropped (DropCnt = 1 with the macro defined).
REQ-037 NonceCount = 0:
- The block stays in RUN for 10000 cycles.
- A new job preempts it: LOAD follows, and no Done pulse is produced.
REQ-038 StartNonce = 0xFFFF_FFFF_FFFF_FFFE: core 3 reports 0x1, which passes through unchanged.
REQ-039 nHashRst asserted during FLUSH: all outputs match REQ-029 within the same cycle.

Source files
------------

// File: rtl/nexus_sched_pkg.sv
// Shared types and constants for the nexus work scheduler.
package nexus_sched_pkg;

   localparam int NONCE_W      = 64;
   localparam int WORK_W       = 1728;
   localparam int PIPE_LAT_DEF = 391;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      FLUSH = 2'd3
   } schedState_t;

endpackage

// File: rtl/nexus_result_fifo.sv
// Result FIFO for the nexus work scheduler; DEPTH must be a power of two.
module nexus_result_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             push,
   input  logic [WIDTH-1:0] pushData,
   input  logic             pop,
   output logic [WIDTH-1:0] popData,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wrPtr;
   logic [AW:0]      rdPtr;
   logic             doPush;
   logic             doPop;

   assign empty   = (wrPtr == rdPtr);
   assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign doPop   = pop && !empty;
   // A pop frees the slot in the same cycle, so a full FIFO can still accept a push.
   assign doPush  = push && (!full || doPop);
   assign popData = empty ? '0 : mem[rdPtr[AW-1:0]];

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
         if (doPop)  rdPtr <= rdPtr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
   end

endmodule

// File: rtl/nexus_work_scheduler.sv
// Job loader, hit collector and round-robin result arbiter for a bank of hash cores.
// Optional NXS_DROP_CNT_EN adds a saturating DropCnt output for lost hits.
module nexus_work_scheduler
   import nexus_sched_pkg::*;
#(
   parameter int HASHERS    = 4,
   parameter int PIPE_LAT   = PIPE_LAT_DEF,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       nHashRst,
   input  logic [WORK_W-1:0]          WorkPkt,
   input  logic [NONCE_W-1:0]         StartNonce,
   input  logic [NONCE_W-1:0]         NonceCount,
   input  logic                       WorkValid,
   output logic                       WorkReady,
   output logic [WORK_W-1:0]          CoreWorkPkt,
   output logic [NONCE_W-1:0]         CoreInNonce,
   output logic                       CoreRstN,
   input  logic [HASHERS-1:0]         CoreGood,
   input  logic [NONCE_W*HASHERS-1:0] CoreNonce,
   output logic [NONCE_W-1:0]         ResultNonce,
   output logic                       ResultValid,
   input  logic                       ResultReady,
   output logic                       Busy,
   output logic                       Done
`ifdef NXS_DROP_CNT_EN
   ,
   output logic [15:0]                DropCnt
`endif
);

   localparam int PTR_W = (HASHERS > 1) ? $clog2(HASHERS) : 1;
   localparam int FL_W  = $clog2(PIPE_LAT + 1);

   schedState_t        state, stateNext;
   logic               hs, afterLoad, maskHits, runDone, flushEnd;
   logic [NONCE_W-1:0] nonceCount, issued;
   logic [FL_W-1:0]    flushCnt;
   logic [HASHERS-1:0] pendV, grant, dropVec;
   logic [NONCE_W-1:0] pendNonce [HASHERS];
   logic [PTR_W-1:0]   rrPtr, gIdx, idx;
   int                 idxInt;
   logic               gValid, grantEn, fifoFull, fifoEmpty, pop;

   assign WorkReady = (state == IDLE) || (state == RUN);
   assign Busy      = (state != IDLE);
   assign hs        = WorkValid && WorkReady;
   assign maskHits  = (state == LOAD) || afterLoad;
   assign runDone   = (nonceCount != '0) &&
                      (({1'b0, issued} + 65'(HASHERS)) >= {1'b0, nonceCount});
   assign flushEnd  = (flushCnt == FL_W'(PIPE_LAT - 1));

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:    if (hs) stateNext = LOAD;
         LOAD:    stateNext = RUN;
         RUN:     if (hs) stateNext = LOAD;
                  else if (runDone) stateNext = FLUSH;
         FLUSH:   if (flushEnd) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nHashRst) begin
      if (!nHashRst) begin
         state       <= IDLE;
         afterLoad   <= 1'b0;
         CoreRstN    <= 1'b0;
         Done        <= 1'b0;
         issued      <= '0;
         flushCnt    <= '0;
         nonceCount  <= '0;
         CoreWorkPkt <= '0;
         CoreInNonce <= '0;
         rrPtr       <= '0;
      end else begin
         state     <= stateNext;
         afterLoad <= (state == LOAD);
         CoreRstN  <= (stateNext != LOAD);
         Done      <= (state == FLUSH) && flushEnd;
         if (hs) begin
            CoreWorkPkt <= WorkPkt;
            CoreInNonce <= StartNonce;
            nonceCount  <= NonceCount;
         end
         issued   <= (state == RUN) ? issued + NONCE_W'(HASHERS) : '0;
         flushCnt <= ((state == FLUSH) && !flushEnd) ? flushCnt + FL_W'(1) : '0;
         if (grantEn)
            rrPtr <= (gIdx == PTR_W'(HASHERS - 1)) ? '0 : gIdx + PTR_W'(1);
      end
   end

   // Round-robin search starting at rrPtr; a job handshake discards in-flight hits.
   always_comb begin
      gValid = 1'b0;
      gIdx   = '0;
      idxInt = 0;
      idx    = '0;
      for (int k = 0; k < HASHERS; k++) begin
         idxInt = (int'(rrPtr) + k) % HASHERS;
         idx    = PTR_W'(idxInt);
         if (!gValid && pendV[idx]) begin
            gValid = 1'b1;
            gIdx   = idx;
         end
      end
   end

   assign grantEn = gValid && !fifoFull && !hs;

   always_comb begin
      grant = '0;
      if (grantEn) grant[gIdx] = 1'b1;
   end

   always_comb begin
      dropVec = '0;
      for (int i = 0; i < HASHERS; i++)
         dropVec[i] = CoreGood[i] && !maskHits && !hs && pendV[i] && !grant[i];
   end

   always_ff @(posedge clk or negedge nHashRst) begin
      if (!nHashRst) begin
         pendV <= '0;
         for (int i = 0; i < HASHERS; i++) pendNonce[i] <= '0;
      end else begin
         for (int i = 0; i < HASHERS; i++) begin
            if (hs) begin
               pendV[i] <= 1'b0;
            end else if (CoreGood[i] && !maskHits && (!pendV[i] || grant[i])) begin
               pendV[i]     <= 1'b1;
               pendNonce[i] <= CoreNonce[NONCE_W*i +: NONCE_W];
            end else if (grant[i]) begin
               pendV[i] <= 1'b0;
            end
         end
      end
   end

   assign ResultValid = !fifoEmpty;
   assign pop         = ResultValid && ResultReady;

   nexus_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (NONCE_W)
   ) uFifo (
      .clk      (clk),
      .rstN     (nHashRst),
      .push     (grantEn),
      .pushData (pendNonce[gIdx]),
      .pop      (pop),
      .popData  (ResultNonce),
      .empty    (fifoEmpty),
      .full     (fifoFull)
   );

`ifdef NXS_DROP_CNT_EN
   function automatic logic [15:0] satAdd16(input logic [15:0] a, input int b);
      logic [16:0] sum;
      sum = {1'b0, a} + 17'(b);
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   always_ff @(posedge clk or negedge nHashRst) begin
      if (!nHashRst)   DropCnt <= '0;
      else if (hs)     DropCnt <= '0;
      else             DropCnt <= satAdd16(DropCnt, $countones(dropVec));
   end
`endif

endmodule

// File: tb/tb_nexus_work_scheduler.sv
// Directed self-checking bench for nexus_work_scheduler (HASHERS=4, PIPE_LAT=391, FIFO_DEPTH=8).
module tb_nexus_work_scheduler;

   logic          clk;
   logic          nHashRst;
   logic [1727:0] WorkPkt;
   logic [63:0]   StartNonce;
   logic [63:0]   NonceCount;
   logic          WorkValid;
   logic          WorkReady;
   logic [1727:0] CoreWorkPkt;
   logic [63:0]   CoreInNonce;
   logic          CoreRstN;
   logic [3:0]    CoreGood;
   logic [255:0]  CoreNonce;
   logic [63:0]   ResultNonce;
   logic          ResultValid;
   logic          ResultReady;
   logic          Busy;
   logic          Done;
`ifdef NXS_DROP_CNT_EN
   logic [15:0]   DropCnt;
`endif

   int nChecks = 0;
   int nFail   = 0;
   int doneCnt = 0;
   int flushCycles;
   int bad;
   logic [1727:0] wp;

   nexus_work_scheduler #(
      .HASHERS    (4),
      .PIPE_LAT   (391),
      .FIFO_DEPTH (8)
   ) dut (
      .clk         (clk),
      .nHashRst    (nHashRst),
      .WorkPkt     (WorkPkt),
      .StartNonce  (StartNonce),
      .NonceCount  (NonceCount),
      .WorkValid   (WorkValid),
      .WorkReady   (WorkReady),
      .CoreWorkPkt (CoreWorkPkt),
      .CoreInNonce (CoreInNonce),
      .CoreRstN    (CoreRstN),
      .CoreGood    (CoreGood),
      .CoreNonce   (CoreNonce),
      .ResultNonce (ResultNonce),
      .ResultValid (ResultValid),
      .ResultReady (ResultReady),
      .Busy        (Busy),
      .Done        (Done)
`ifdef NXS_DROP_CNT_EN
      ,
      .DropCnt     (DropCnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (Done === 1'b1) doneCnt++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetState(input string tag);
      chk({tag, "_ready"}, 64'(WorkReady), 64'd1);
      chk({tag, "_corerst"}, 64'(CoreRstN), 64'd0);
      chk({tag, "_busy"}, 64'(Busy), 64'd0);
      chk({tag, "_done"}, 64'(Done), 64'd0);
      chk({tag, "_rvalid"}, 64'(ResultValid), 64'd0);
      chk({tag, "_rnonce"}, ResultNonce, 64'd0);
      chk({tag, "_innonce"}, CoreInNonce, 64'd0);
      chk({tag, "_workpkt_zero"}, 64'(CoreWorkPkt === '0), 64'd1);
   endtask

   initial begin
      nHashRst = 1'b0; WorkValid = 1'b0; WorkPkt = '0; StartNonce = '0;
      NonceCount = '0; CoreGood = '0; CoreNonce = '0; ResultReady = 1'b0;
      wp = {27{64'hDEAD_BEEF_0123_4567}};
      #2;
      checkResetState("rst0");
      tick(); tick();
      nHashRst = 1'b1;
      tick();

      // Bounded job: 1 LOAD, 2 RUN, 391 FLUSH, one Done
      WorkPkt = wp; StartNonce = 64'h100; NonceCount = 64'd8; WorkValid = 1'b1;
      tick();
      WorkValid = 1'b0;
      chk("load_corerst", 64'(CoreRstN), 64'd0);
      chk("load_ready", 64'(WorkReady), 64'd0);
      chk("load_busy", 64'(Busy), 64'd1);
      chk("load_innonce", CoreInNonce, 64'h100);
      chk("load_workpkt", 64'(CoreWorkPkt === wp), 64'd1);
      tick();
      chk("run1_corerst", 64'(CoreRstN), 64'd1);
      chk("run1_ready", 64'(WorkReady), 64'd1);
      tick();
      chk("run2_ready", 64'(WorkReady), 64'd1);
      tick();
      chk("flush_ready", 64'(WorkReady), 64'd0);
      chk("flush_busy", 64'(Busy), 64'd1);
      flushCycles = 0;
      while (Busy && flushCycles < 1000) begin
         flushCycles++;
         tick();
      end
      chk("flush_len", 64'(flushCycles), 64'd391);
      chk("done_pulse_hi", 64'(Done), 64'd1);
      tick();
      chk("done_pulse_lo", 64'(Done), 64'd0);
      chk("done_count1", 64'(doneCnt), 64'd1);

      // Round-robin: cores 0,1,3 together, two-edge latency to ResultValid
      ResultReady = 1'b1;
      for (int i = 0; i < 4; i++) CoreNonce[64*i +: 64] = 64'h1000 + 64'(i);
      CoreGood = 4'b1011;
      tick();
      CoreGood = 4'b0000;
      chk("lat_not_yet", 64'(ResultValid), 64'd0);
      tick();
      chk("rr_v0", 64'(ResultValid), 64'd1);
      chk("rr_n0", ResultNonce, 64'h1000);
      tick();
      chk("rr_n1", ResultNonce, 64'h1001);
      tick();
      chk("rr_n3", ResultNonce, 64'h1003);
      tick();
      chk("rr_empty", 64'(ResultValid), 64'd0);
      for (int i = 0; i < 4; i++) CoreNonce[64*i +: 64] = 64'h2000 + 64'(i);
      CoreGood = 4'b1001;
      tick();
      CoreGood = 4'b0000;
      tick();
      chk("rr_wrap_first", ResultNonce, 64'h2000);
      tick();
      chk("rr_wrap_second", ResultNonce, 64'h2003);
      tick();

      // Backpressure: 8 in FIFO, 9th held in pending, 10th dropped
      ResultReady = 1'b0;
      for (int k = 0; k < 9; k++) begin
         CoreNonce[128 +: 64] = 64'h3000 + 64'(k);
         CoreGood = 4'b0100;
         tick();
      end
      CoreGood = 4'b0000;
      tick(); tick();
      chk("full_valid", 64'(ResultValid), 64'd1);
      chk("full_head", ResultNonce, 64'h3000);
      CoreNonce[128 +: 64] = 64'h3009;
      CoreGood = 4'b0100;
      tick();
      CoreGood = 4'b0000;
`ifdef NXS_DROP_CNT_EN
      chk("dropcnt_one", 64'(DropCnt), 64'd1);
`endif
      ResultReady = 1'b1;
      for (int k = 0; k < 9; k++) begin
         chk("drain_valid", 64'(ResultValid), 64'd1);
         chk("drain_nonce", ResultNonce, 64'h3000 + 64'(k));
         tick();
      end
      chk("drain_empty", 64'(ResultValid), 64'd0);

      // Unbounded job with wrapping start nonce; hits masked around LOAD
      StartNonce = 64'hFFFF_FFFF_FFFF_FFFE; NonceCount = 64'd0; WorkValid = 1'b1;
      tick();
      WorkValid = 1'b0;
      chk("wrap_innonce", CoreInNonce, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("wrap_load_corerst", 64'(CoreRstN), 64'd0);
`ifdef NXS_DROP_CNT_EN
      chk("dropcnt_cleared", 64'(DropCnt), 64'd0);
`endif
      CoreNonce[0 +: 64] = 64'hBAD;
      CoreGood = 4'b0001;
      tick(); tick();
      CoreGood = 4'b0000;
      tick(); tick();
      chk("mask_no_result", 64'(ResultValid), 64'd0);
      CoreNonce[192 +: 64] = 64'h1;
      CoreGood = 4'b1000;
      tick();
      CoreGood = 4'b0000;
      tick();
      chk("wrap_valid", 64'(ResultValid), 64'd1);
      chk("wrap_nonce", ResultNonce, 64'h1);
      tick();
      chk("wrap_empty", 64'(ResultValid), 64'd0);
      bad = 0;
      for (int i = 0; i < 10000; i++) begin
         if (!(Busy && WorkReady && CoreRstN)) bad++;
         tick();
      end
      chk("unbounded_stays_run", 64'(bad), 64'd0);

      // Preempt with a short bounded job, then reset mid-FLUSH
      StartNonce = 64'h500; NonceCount = 64'd4; WorkValid = 1'b1;
      tick();
      WorkValid = 1'b0;
      chk("preempt_corerst", 64'(CoreRstN), 64'd0);
      chk("preempt_ready", 64'(WorkReady), 64'd0);
      chk("preempt_innonce", CoreInNonce, 64'h500);
      tick();
      chk("preempt_run_ready", 64'(WorkReady), 64'd1);
      tick();
      chk("preempt_flush_ready", 64'(WorkReady), 64'd0);
      chk("preempt_flush_busy", 64'(Busy), 64'd1);
      chk("preempt_no_done", 64'(doneCnt), 64'd1);
      ResultReady = 1'b0;
      CoreNonce[0 +: 64] = 64'h777;
      CoreGood = 4'b0001;
      tick();
      CoreGood = 4'b0000;
      tick();
      chk("flush_hit_valid", 64'(ResultValid), 64'd1);
      chk("flush_hit_nonce", ResultNonce, 64'h777);
      tick(); tick(); tick();
      #3;
      nHashRst = 1'b0;
      #1;
      checkResetState("rst_flush");
      tick(); tick();
      nHashRst = 1'b1;
      bad = 0;
      for (int i = 0; i < 500; i++) begin
         if (Busy !== 1'b0) bad++;
         tick();
      end
      chk("after_rst_idle", 64'(bad), 64'd0);
      chk("after_rst_no_done", 64'(doneCnt), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
